// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: instruction field
// codes, the controller state encoding and default exception settings.
package multdiv_pkg;

   localparam logic [4:0] RTYPE_OPCODE = 5'b00000;
   localparam logic [4:0] ALU_OP_MUL   = 5'b00110;
   localparam logic [4:0] ALU_OP_DIV   = 5'b00111;

   localparam int DEFAULT_TIMEOUT      = 40;
   localparam int DEFAULT_MUL_EXC_CODE = 4;
   localparam int DEFAULT_DIV_EXC_CODE = 5;
   localparam int DEFAULT_RSTATUS_REG  = 30;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      WB     = 2'd3
   } state_e;

endpackage

// File: rtl/multdiv_decode.sv
// Pure combinational decode of a DX instruction into mul/div flags and the
// destination register; shared with the hazard logic.
module multdiv_decode
   import multdiv_pkg::*;
(
   input  logic [31:0] insn,
   output logic        is_mul,
   output logic        is_div,
   output logic [4:0]  rd
);

   logic [16:0] unused_insn_bits;

   assign unused_insn_bits = {insn[21:7], insn[1:0]};

   // Classify the instruction from its opcode and ALU op fields
   always_comb begin
      is_mul = (insn[31:27] == RTYPE_OPCODE) && (insn[6:2] == ALU_OP_MUL);
      is_div = (insn[31:27] == RTYPE_OPCODE) && (insn[6:2] == ALU_OP_DIV);
      rd     = insn[26:22];
   end

endmodule

// File: rtl/multdiv_controller.sv
// Sequencer for the shared multiplier/divider: accepts one op from DX,
// pulses the unit once, stalls the front end, and hands the result (or an
// rstatus exception code) to the register-file write port.
module multdiv_controller
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT      = DEFAULT_TIMEOUT,
   parameter int MUL_EXC_CODE = DEFAULT_MUL_EXC_CODE,
   parameter int DIV_EXC_CODE = DEFAULT_DIV_EXC_CODE,
   parameter int RSTATUS_REG  = DEFAULT_RSTATUS_REG
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_insn,
   input  logic        dx_valid,
   input  logic [31:0] dx_opA,
   input  logic [31:0] dx_opB,
   output logic        dx_flush,
   output logic        stall,
   output logic        busy,
   output logic        md_ctrl_mult,
   output logic        md_ctrl_div,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   input  logic        wb_ack,
   output logic        timeout_err
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic        dec_is_mul;
   logic        dec_is_div;
   logic [4:0]  dec_rd;
   logic        accept;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        opa_q, opa_d;
   logic [31:0]        opb_q, opb_d;
   logic [4:0]         rd_q, rd_d;
   logic               div_q, div_d;
   logic [31:0]        result_q, result_d;
   logic               exc_q, exc_d;
   logic               timeout_err_q, timeout_err_d;

   multdiv_decode u_decode (
      .insn   (dx_insn),
      .is_mul (dec_is_mul),
      .is_div (dec_is_div),
      .rd     (dec_rd)
   );

   assign accept      = dx_valid & (dec_is_mul | dec_is_div) & (state_q == IDLE);
   assign md_operandA = opa_q;
   assign md_operandB = opb_q;
   assign timeout_err = timeout_err_q;

   // State register plus operand/result latches, cleared by synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         opa_q         <= '0;
         opb_q         <= '0;
         rd_q          <= '0;
         div_q         <= 1'b0;
         result_q      <= '0;
         exc_q         <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         rd_q          <= rd_d;
         div_q         <= div_d;
         result_q      <= result_d;
         exc_q         <= exc_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next state, wait counter and latch updates; a result arriving on the
   // last count takes priority over the timeout
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      rd_d          = rd_q;
      div_d         = div_q;
      result_d      = result_q;
      exc_d         = exc_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               opa_d   = dx_opA;
               opb_d   = dx_opB;
               rd_d    = dec_rd;
               div_d   = dec_is_div;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (md_resultRDY) begin
               result_d = md_result;
               exc_d    = md_exception;
               state_d  = ((rd_q == 5'd0) && !md_exception) ? IDLE : WB;
            end else if (cnt_q == CNT_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
         WB: begin
            if (wb_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall/flush, start pulses and the writeback request derived from state
   always_comb begin
      stall        = accept | (state_q != IDLE);
      dx_flush     = accept;
      busy         = (state_q != IDLE);
      md_ctrl_mult = (state_q == LAUNCH) & ~div_q;
      md_ctrl_div  = (state_q == LAUNCH) & div_q;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      if (state_q == WB) begin
         wb_valid = 1'b1;
         if (exc_q) begin
            wb_rd   = 5'(RSTATUS_REG);
            wb_data = div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
         end else begin
            wb_rd   = rd_q;
            wb_data = result_q;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: plays the role of the DX stage, the
// multdiv unit and the regfile port, and compares against a plain
// arithmetic model of what each instruction should write back.
module tb_multdiv_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] dx_insn;
   logic        dx_valid;
   logic [31:0] dx_opA;
   logic [31:0] dx_opB;
   logic        dx_flush;
   logic        stall;
   logic        busy;
   logic        md_ctrl_mult;
   logic        md_ctrl_div;
   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ack;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;
   bit exp_timeout_err = 1'b0;

   localparam longint MAX32 = 64'sd2147483647;
   localparam longint MIN32 = -MAX32 - 1;

   multdiv_controller #(
      .TIMEOUT      (40),
      .MUL_EXC_CODE (4),
      .DIV_EXC_CODE (5),
      .RSTATUS_REG  (30)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .dx_insn      (dx_insn),
      .dx_valid     (dx_valid),
      .dx_opA       (dx_opA),
      .dx_opB       (dx_opB),
      .dx_flush     (dx_flush),
      .stall        (stall),
      .busy         (busy),
      .md_ctrl_mult (md_ctrl_mult),
      .md_ctrl_div  (md_ctrl_div),
      .md_operandA  (md_operandA),
      .md_operandB  (md_operandB),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_ack       (wb_ack),
      .timeout_err  (timeout_err)
   );

   // Free-running clock
   always #5 clock = ~clock;

   function automatic logic [31:0] make_insn(input bit is_div, input logic [4:0] rd);
      logic [31:0] r;
      r        = $urandom;
      r[31:27] = 5'b00000;
      r[26:22] = rd;
      r[6:2]   = is_div ? 5'b00111 : 5'b00110;
      return r;
   endfunction

   // Behavioural multdiv unit: signed arithmetic, exception on overflow or /0
   task automatic model_unit(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output bit exc);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_div) begin
         if (sb == 0) begin
            r = 0;
            exc = 1'b1;
         end else begin
            r = sa / sb;
            exc = (r > MAX32) || (r < MIN32);
         end
      end else begin
         r = sa * sb;
         exc = (r > MAX32) || (r < MIN32);
      end
      res = r[31:0];
   endtask

   task automatic check_idle(input string name);
      @(negedge clock);
      dx_valid = 1'b0;
      wb_ack = 1'b0;
      md_resultRDY = 1'b0;
      #1;
      checks++;
      if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 6'b000000) begin
         failures++;
         $display("[TB] FAIL %s_flags got=%b exp=000000", name,
                  {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid});
      end
      checks++;
      if ({wb_rd, wb_data, timeout_err} !== {5'd0, 32'd0, exp_timeout_err}) begin
         failures++;
         $display("[TB] FAIL %s_wb got rd=%0d data=%h terr=%b exp rd=0 data=0 terr=%b",
                  name, wb_rd, wb_data, timeout_err, exp_timeout_err);
      end
   endtask

   // One complete operation; ends on the last non-IDLE cycle so the next
   // call lands on the first IDLE cycle (back-to-back acceptance)
   task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input int rdy_delay, input int ack_wait,
                         input bit noisy);
      logic [31:0] res;
      bit          exc;
      bit          exp_wb;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic [5:0]  exp_flags;
      model_unit(is_div, a, b, res, exc);
      exp_wb   = exc || (rd != 5'd0);
      exp_rd   = exc ? 5'd30 : rd;
      exp_data = exc ? (is_div ? 32'd5 : 32'd4) : res;

      @(negedge clock);
      dx_insn = make_insn(is_div, rd);
      dx_valid = 1'b1;
      dx_opA = a;
      dx_opB = b;
      md_resultRDY = 1'b0;
      wb_ack = 1'b0;
      #1;
      checks++;
      if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 6'b110000) begin
         failures++;
         $display("[TB] FAIL accept got=%b exp=110000",
                  {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid});
      end

      @(negedge clock);
      dx_valid = noisy;
      dx_insn = make_insn($urandom_range(0, 1), 5'($urandom));
      dx_opA = $urandom;
      dx_opB = $urandom;
      md_resultRDY = noisy;
      md_result = $urandom;
      md_exception = 1'($urandom);
      #1;
      exp_flags = {1'b1, 1'b0, 1'b1, ~is_div, is_div, 1'b0};
      checks++;
      if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== exp_flags) begin
         failures++;
         $display("[TB] FAIL launch got=%b exp=%b",
                  {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid}, exp_flags);
      end
      checks++;
      if ({md_operandA, md_operandB} !== {a, b}) begin
         failures++;
         $display("[TB] FAIL operands got=%h/%h exp=%h/%h", md_operandA, md_operandB, a, b);
      end

      for (int k = 1; k <= rdy_delay; k++) begin
         @(negedge clock);
         wb_ack = noisy ? 1'($urandom) : 1'b0;
         dx_valid = noisy ? 1'($urandom) : 1'b0;
         dx_insn = make_insn($urandom_range(0, 1), 5'($urandom));
         if (k == rdy_delay) begin
            md_resultRDY = 1'b1;
            md_result = res;
            md_exception = exc;
         end else begin
            md_resultRDY = 1'b0;
            md_result = $urandom;
            md_exception = 1'($urandom);
         end
         #1;
         checks++;
         if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 6'b101000) begin
            failures++;
            $display("[TB] FAIL wait_cycle%0d got=%b exp=101000", k,
                     {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid});
         end
      end

      @(negedge clock);
      md_resultRDY = 1'b0;
      md_exception = 1'($urandom);
      md_result = $urandom;
      dx_valid = 1'b0;
      wb_ack = 1'b0;
      if (exp_wb) begin
         for (int w = 0; w <= ack_wait; w++) begin
            if (w > 0) @(negedge clock);
            wb_ack = (w == ack_wait);
            #1;
            checks++;
            if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 6'b101001) begin
               failures++;
               $display("[TB] FAIL wb_flags cycle%0d got=%b exp=101001", w,
                        {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid});
            end
            checks++;
            if ({wb_rd, wb_data} !== {exp_rd, exp_data}) begin
               failures++;
               $display("[TB] FAIL wb_payload cycle%0d got rd=%0d data=%h exp rd=%0d data=%h",
                        w, wb_rd, wb_data, exp_rd, exp_data);
            end
         end
      end else begin
         #1;
         checks++;
         if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid} !== 6'b000000) begin
            failures++;
            $display("[TB] FAIL no_wb_idle got=%b exp=000000",
                     {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid});
         end
      end
      checks++;
      if (timeout_err !== exp_timeout_err) begin
         failures++;
         $display("[TB] FAIL op_timeout_err got=%b exp=%b", timeout_err, exp_timeout_err);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      dx_insn = '0;
      dx_valid = 1'b0;
      dx_opA = '0;
      dx_opB = '0;
      md_result = '0;
      md_exception = 1'b0;
      md_resultRDY = 1'b0;
      wb_ack = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid, timeout_err} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got=%b exp=0000000",
                  {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid, timeout_err});
      end
      checks++;
      if ({md_operandA, md_operandB, wb_rd, wb_data} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data got opA=%h opB=%h rd=%0d data=%h exp all 0",
                  md_operandA, md_operandB, wb_rd, wb_data);
      end
   endtask

   task automatic test_non_multdiv;
      logic [31:0] insn;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         insn = make_insn(1'($urandom), 5'($urandom));
         case (i % 3)
            0: insn[31:27] = 5'($urandom_range(1, 31));
            1: insn[6:2] = 5'($urandom_range(8, 31));
            default: ;
         endcase
         dx_insn = insn;
         dx_valid = (i % 3) != 2;
         #1;
         checks++;
         if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL non_multdiv insn=%h valid=%b got=%b exp=00000", insn, dx_valid,
                     {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div});
         end
      end
      check_idle("non_multdiv_after");
   endtask

   task automatic test_mul_basic;
      run_op(1'b0, 5'd3, 32'd7, 32'd6, 17, 0, 1'b0);
      check_idle("mul_basic_after");
   endtask

   task automatic test_exceptions;
      run_op(1'b1, 5'd4, 32'd123, 32'd0, 5, 0, 1'b0);
      check_idle("div_exc_after");
      run_op(1'b0, 5'd9, 32'h7fffffff, 32'd2, 3, 0, 1'b0);
      check_idle("mul_exc_after");
   endtask

   task automatic test_rd_zero;
      run_op(1'b0, 5'd0, 32'd5, 32'd5, 4, 0, 1'b0);
      check_idle("rd_zero_after");
   endtask

   task automatic test_ack_withheld;
      run_op(1'b1, 5'd12, 32'd100, 32'd7, 6, 3, 1'b1);
      check_idle("ack_withheld_after");
   endtask

   task automatic test_rdy_last_count;
      run_op(1'b0, 5'd5, 32'hffff_fff0, 32'd3, 40, 1, 1'b0);
      check_idle("rdy_last_after");
   endtask

   task automatic test_timeout;
      @(negedge clock);
      dx_insn = make_insn(1'b1, 5'd8);
      dx_valid = 1'b1;
      dx_opA = 32'd50;
      dx_opB = 32'd5;
      @(negedge clock);
      dx_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         #1;
         checks++;
         if ({busy, wb_valid, timeout_err} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL timeout_wait%0d got=%b exp=100", k, {busy, wb_valid, timeout_err});
         end
      end
      exp_timeout_err = 1'b1;
      check_idle("timeout_abort");
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         md_resultRDY = 1'b1;
         md_result = $urandom;
         #1;
         checks++;
         if ({busy, stall, wb_valid, timeout_err} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL late_rdy%0d got=%b exp=0001", k, {busy, stall, wb_valid, timeout_err});
         end
      end
      @(negedge clock);
      md_resultRDY = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_timeout_err = 1'b0;
      #1;
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_err_cleared got=%b exp=0", timeout_err);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clock);
      dx_insn = make_insn(1'b0, 5'd6);
      dx_valid = 1'b1;
      dx_opA = $urandom;
      dx_opB = $urandom;
      @(negedge clock);
      dx_valid = 1'b0;
      repeat (5) @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      md_resultRDY = 1'b1;
      md_result = $urandom;
      md_exception = 1'b0;
      #1;
      checks++;
      if ({stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid, md_operandA, md_operandB,
           wb_rd, wb_data} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_mid_outputs got flags=%b opA=%h opB=%h rd=%0d data=%h exp all 0",
                  {stall, dx_flush, busy, md_ctrl_mult, md_ctrl_div, wb_valid},
                  md_operandA, md_operandB, wb_rd, wb_data);
      end
      @(negedge clock);
      #1;
      checks++;
      if ({busy, wb_valid, md_ctrl_mult, md_ctrl_div} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_mid_stale_rdy got=%b exp=0000",
                  {busy, wb_valid, md_ctrl_mult, md_ctrl_div});
      end
      run_op(1'b0, 5'd7, 32'd3, 32'd5, 2, 0, 1'b0);
      check_idle("reset_mid_after");
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      logic [4:0]  rd;
      for (int i = 0; i < 15; i++) begin
         a  = $urandom;
         b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
         rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         run_op(1'($urandom), rd, a, b, $urandom_range(1, 40), $urandom_range(0, 3), 1'b1);
      end
      check_idle("back_to_back_after");
   endtask

   // Bound on total run time in case the stimulus ever stalls
   initial begin
      #400000;
      failures++;
      $display("[TB] FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Scenario sequence
   initial begin
      test_reset();
      test_non_multdiv();
      test_mul_basic();
      test_exceptions();
      test_rd_zero();
      test_ack_withheld();
      test_rdy_last_count();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
